alu_wb_ctrl: RTL and testbench

Sequencer and ALU that sits around the 16x4 register bank and drives both its read ports and its write port. It accepts one register-to-register command (op, rd, rs1, rs2) and reads rs1/rs2 through the bank's asynchronous read ports. It computes a 4-bit result and performs a single-cycle RegWrite into rd. It replaces hand-driven addrW/datW/RegWrite stimulus with a controlled, one-pulse write-back path.

---
 rtl/alu_wb_ctrl.sv | 177 +++++++++++++++++
 tb/tb_alu_wb_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_ctrl.sv
// Register-bank sequencer and 4-bit ALU: accepted command -> RegWrite 3 cycles later -> done 4 cycles later.
// Not pipelined; start is only honoured in IDLE, so commands that arrive while busy are dropped.
module alu_wb_ctrl #(
    parameter int DAT_WIDTH  = 4,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic [ADDR_WIDTH-1:0] addrRa,
    output logic [ADDR_WIDTH-1:0] addrRb,
    input  logic [DAT_WIDTH-1:0]  datOutRa,
    input  logic [DAT_WIDTH-1:0]  datOutRb,
    output logic [ADDR_WIDTH-1:0] addrW,
    output logic [DAT_WIDTH-1:0]  datW,
    output logic                  RegWrite,
    output logic                  busy,
    output logic                  done,
    output logic                  flag_c,
    output logic                  flag_z
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_SHL = 3'b111;

    state_t                r_state;
    state_t                w_next;
    logic                  w_accept;

    logic [2:0]            r_op;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic [ADDR_WIDTH-1:0] r_addrRa;
    logic [ADDR_WIDTH-1:0] r_addrRb;
    logic [DAT_WIDTH-1:0]  r_opA;
    logic [DAT_WIDTH-1:0]  r_opB;
    logic [ADDR_WIDTH-1:0] r_addrW;
    logic [DAT_WIDTH-1:0]  r_datW;
    logic                  r_regwrite;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_flag_c;
    logic                  r_flag_z;

    logic [DAT_WIDTH:0]    w_sum;
    logic [DAT_WIDTH:0]    w_diff;
    logic [DAT_WIDTH-1:0]  w_res;
    logic                  w_c;
    logic                  w_z;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_READ;
                end
            end
            S_READ:  w_next = S_EXEC;
            S_EXEC:  w_next = S_WRITE;
            S_WRITE: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Extra top bit of the sum/difference is the carry-out / borrow.
    assign w_sum  = {1'b0, r_opA} + {1'b0, r_opB};
    assign w_diff = {1'b0, r_opA} - {1'b0, r_opB};

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_res = w_sum[DAT_WIDTH-1:0];
                w_c   = w_sum[DAT_WIDTH];
            end
            OP_SUB: begin
                w_res = w_diff[DAT_WIDTH-1:0];
                w_c   = w_diff[DAT_WIDTH];
            end
            OP_AND: w_res = r_opA & r_opB;
            OP_OR:  w_res = r_opA | r_opB;
            OP_XOR: w_res = r_opA ^ r_opB;
            OP_NOT: w_res = ~r_opA;
            OP_MOV: w_res = r_opA;
            OP_SHL: begin
                w_res = {r_opA[DAT_WIDTH-2:0], 1'b0};
                w_c   = r_opA[DAT_WIDTH-1];
            end
            default: begin
                w_res = '0;
                w_c   = 1'b0;
            end
        endcase
    end

    assign w_z = (w_res == '0);

    // Control outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op       <= '0;
            r_rd       <= '0;
            r_addrRa   <= '0;
            r_addrRb   <= '0;
            r_opA      <= '0;
            r_opB      <= '0;
            r_addrW    <= '0;
            r_datW     <= '0;
            r_regwrite <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_flag_c   <= 1'b0;
            r_flag_z   <= 1'b0;
        end else begin
            r_regwrite <= (w_next == S_WRITE);
            r_done     <= (w_next == S_DONE);
            r_busy     <= (w_next != S_IDLE);
            if (w_accept) begin
                r_op     <= op;
                r_rd     <= rd;
                r_addrRa <= rs1;
                r_addrRb <= rs2;
            end
            if (r_state == S_READ) begin
                r_opA <= datOutRa;
                r_opB <= datOutRb;
            end
            if (r_state == S_EXEC) begin
                r_addrW  <= r_rd;
                r_datW   <= w_res;
                r_flag_c <= w_c;
                r_flag_z <= w_z;
            end
        end
    end

    assign addrRa   = r_addrRa;
    assign addrRb   = r_addrRb;
    assign addrW    = r_addrW;
    assign datW     = r_datW;
    assign RegWrite = r_regwrite;
    assign busy     = r_busy;
    assign done     = r_done;
    assign flag_c   = r_flag_c;
    assign flag_z   = r_flag_z;

endmodule

// File: tb/tb_alu_wb_ctrl.sv
// Directed bench for alu_wb_ctrl with a behavioural 16x4 register bank and a preload write mux.
module tb_alu_wb_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] addrRa;
    logic [3:0] addrRb;
    logic [3:0] datOutRa;
    logic [3:0] datOutRb;
    logic [3:0] addrW;
    logic [3:0] datW;
    logic       RegWrite;
    logic       busy;
    logic       done;
    logic       flag_c;
    logic       flag_z;

    logic [3:0] bank [16];
    logic       clr_bank;
    logic       tb_we;
    logic [3:0] tb_addr;
    logic [3:0] tb_dat;

    int n_chk;
    int n_err;

    alu_wb_ctrl #(.DAT_WIDTH(4), .ADDR_WIDTH(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .addrRa   (addrRa),
        .addrRb   (addrRb),
        .datOutRa (datOutRa),
        .datOutRb (datOutRb),
        .addrW    (addrW),
        .datW     (datW),
        .RegWrite (RegWrite),
        .busy     (busy),
        .done     (done),
        .flag_c   (flag_c),
        .flag_z   (flag_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign datOutRa = bank[addrRa];
    assign datOutRb = bank[addrRb];

    always @(posedge clk) begin
        if (clr_bank) begin
            for (int i = 0; i < 16; i++) bank[i] <= 4'h0;
        end else if (tb_we) begin
            bank[tb_addr] <= tb_dat;
        end else if (RegWrite) begin
            bank[addrW] <= datW;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".addrRa"},   32'(addrRa),   32'd0);
        chk({tag, ".addrRb"},   32'(addrRb),   32'd0);
        chk({tag, ".addrW"},    32'(addrW),    32'd0);
        chk({tag, ".datW"},     32'(datW),     32'd0);
        chk({tag, ".RegWrite"}, 32'(RegWrite), 32'd0);
        chk({tag, ".busy"},     32'(busy),     32'd0);
        chk({tag, ".done"},     32'(done),     32'd0);
        chk({tag, ".flag_c"},   32'(flag_c),   32'd0);
        chk({tag, ".flag_z"},   32'(flag_z),   32'd0);
    endtask

    // One command, checked cycle by cycle; k counts negedges after the accepting edge.
    // With poke set, start is held high through READ and EXEC and must be ignored.
    task automatic run_cmd(input string tag, input logic [2:0] o, input logic [3:0] d,
                           input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] er, input logic ec, input logic ez, input bit poke);
        @(negedge clk);
        op = o; rd = d; rs1 = a; rs2 = b; start = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = poke;
                op = ~o; rd = ~d; rs1 = ~a; rs2 = ~b;
                chk({tag, ".addrRa"}, 32'(addrRa), 32'(a));
                chk({tag, ".addrRb"}, 32'(addrRb), 32'(b));
            end
            if (k == 3) begin
                start = 1'b0;
                chk({tag, ".addrW"},  32'(addrW),  32'(d));
                chk({tag, ".datW"},   32'(datW),   32'(er));
                chk({tag, ".flag_c"}, 32'(flag_c), 32'(ec));
                chk({tag, ".flag_z"}, 32'(flag_z), 32'(ez));
            end
            chk({tag, ".RegWrite"}, 32'(RegWrite), 32'(k == 3));
            chk({tag, ".done"},     32'(done),     32'(k == 4));
            chk({tag, ".busy"},     32'(busy),     32'(k <= 4));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rw_cnt;
        int d_first;
        int d_second;
        int d_cnt;

        n_chk = 0; n_err = 0;
        rst = 1'b0; start = 1'b0; op = 3'd0; rd = 4'd0; rs1 = 4'd0; rs2 = 4'd0;
        clr_bank = 1'b1; tb_we = 1'b0; tb_addr = 4'd0; tb_dat = 4'd0;

        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        clr_bank = 1'b0;

        @(negedge clk);
        tb_we = 1'b1; tb_addr = 4'd3; tb_dat = 4'd2;
        @(negedge clk);
        tb_addr = 4'd10; tb_dat = 4'd8;
        @(negedge clk);
        tb_we = 1'b0;

        run_cmd("add7",  3'b000, 4'd7,  4'd3,  4'd10, 4'hA, 1'b0, 1'b0, 1'b0);
        chk("bank.r7", 32'(bank[7]), 32'd10);
        run_cmd("sub0",  3'b001, 4'd0,  4'd3,  4'd10, 4'hA, 1'b1, 1'b0, 1'b0);
        chk("bank.r0", 32'(bank[0]), 32'd10);
        run_cmd("add5",  3'b000, 4'd5,  4'd10, 4'd10, 4'h0, 1'b1, 1'b1, 1'b0);
        run_cmd("shl3",  3'b111, 4'd3,  4'd3,  4'd0,  4'h4, 1'b0, 1'b0, 1'b0);
        chk("bank.r3", 32'(bank[3]), 32'd4);
        run_cmd("mov12", 3'b110, 4'd12, 4'd3,  4'd0,  4'h4, 1'b0, 1'b0, 1'b0);
        chk("bank.r12", 32'(bank[12]), 32'd4);
        run_cmd("and1",  3'b010, 4'd1,  4'd7,  4'd10, 4'h8, 1'b0, 1'b0, 1'b0);
        run_cmd("or2",   3'b011, 4'd2,  4'd7,  4'd12, 4'hE, 1'b0, 1'b0, 1'b0);
        run_cmd("xor4",  3'b100, 4'd4,  4'd7,  4'd7,  4'h0, 1'b0, 1'b1, 1'b0);
        run_cmd("not6",  3'b101, 4'd6,  4'd7,  4'd0,  4'h5, 1'b0, 1'b0, 1'b0);
        run_cmd("sub8",  3'b001, 4'd8,  4'd7,  4'd12, 4'h6, 1'b0, 1'b0, 1'b0);
        run_cmd("shlc",  3'b111, 4'd11, 4'd7,  4'd0,  4'h4, 1'b1, 1'b0, 1'b0);
        run_cmd("poke",  3'b000, 4'd13, 4'd12, 4'd12, 4'h8, 1'b0, 1'b0, 1'b1);
        chk("bank.r13", 32'(bank[13]), 32'd8);

        // start held high across 10 edges: accepts at edge 0 and edge 5 only
        rw_cnt = 0; d_cnt = 0; d_first = -1; d_second = -1;
        @(negedge clk);
        op = 3'b000; rd = 4'd14; rs1 = 4'd3; rs2 = 4'd3; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (RegWrite) rw_cnt++;
            if (done) begin
                if (d_cnt == 0) d_first = i;
                else if (d_cnt == 1) d_second = i;
                d_cnt++;
            end
            if (i == 9) start = 1'b0;
        end
        chk("hold.regwrites", 32'(rw_cnt), 32'd2);
        chk("hold.dones",     32'(d_cnt),  32'd2);
        chk("hold.done1",     32'(d_first),  32'd3);
        chk("hold.done2",     32'(d_second), 32'd8);
        chk("bank.r14", 32'(bank[14]), 32'd8);

        // reset during EXEC of ADD rd=9: nothing written, nothing replayed
        @(negedge clk);
        op = 3'b000; rd = 4'd9; rs1 = 4'd3; rs2 = 4'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_all_zero("midrst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        rw_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (RegWrite || busy) rw_cnt++;
        end
        chk("midrst.no_replay", 32'(rw_cnt), 32'd0);
        chk("bank.r9_kept", 32'(bank[9]), 32'd0);
        run_cmd("add9", 3'b000, 4'd9, 4'd3, 4'd3, 4'h8, 1'b0, 1'b0, 1'b0);
        chk("bank.r9", 32'(bank[9]), 32'd8);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
